// File: rtl/pair_reg_file.sv
// Byte/pair register file with two combinational read ports, one write port and
// a valid/ready pair-op port (INC, DEC, INC2, ADDI, two-cycle XCHG) with zero/carry status.
module pair_reg_file #(
    parameter int DATA_W    = 8,
    parameter int NUM_PAIRS = 6,
    parameter int IDX_W     = $clog2(2 * NUM_PAIRS),
    parameter int PAIR_W    = $clog2(NUM_PAIRS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W:0]        rd_a_sel,
    output logic [2*DATA_W-1:0]   rd_a_data,
    input  logic [IDX_W:0]        rd_b_sel,
    output logic [2*DATA_W-1:0]   rd_b_data,
    input  logic                  we,
    input  logic [IDX_W:0]        wr_sel,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [PAIR_W-1:0]     op_pair,
    input  logic [PAIR_W-1:0]     op_pair2,
    input  logic [DATA_W-1:0]     op_imm,
    output logic                  op_done,
    output logic                  op_zero,
    output logic                  op_carry
);

    localparam int NUM_REGS = 2 * NUM_PAIRS;
    localparam int PW       = 2 * DATA_W;
    localparam logic [IDX_W:0]  REG_LIMIT  = (IDX_W + 1)'(NUM_REGS);
    localparam logic [PAIR_W:0] PAIR_LIMIT = (PAIR_W + 1)'(NUM_PAIRS);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_INC  = 3'd1,
        OP_DEC  = 3'd2,
        OP_INC2 = 3'd3,
        OP_ADDI = 3'd4,
        OP_XCHG = 3'd5
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        XCHG2 = 1'b1
    } state_t;

    logic [DATA_W-1:0] r [NUM_REGS];
    logic [PW-1:0]     temp;
    logic [PAIR_W-1:0] xchg_b;
    logic              xchg_ok;
    state_t            state, state_next;
    logic              done_next;

    function automatic logic [PW-1:0] read_sel(input logic [IDX_W:0] sel);
        logic [IDX_W-1:0] idx, hi, lo;
        idx = sel[IDX_W-1:0];
        hi  = {idx[IDX_W-1:1], 1'b0};
        lo  = {idx[IDX_W-1:1], 1'b1};
        read_sel = '0;
        if ({1'b0, idx} < REG_LIMIT) begin
            if (sel[IDX_W]) read_sel = {r[hi], r[lo]};
            else            read_sel = {{DATA_W{1'b0}}, r[idx]};
        end
    endfunction

    assign rd_a_data = read_sel(rd_a_sel);
    assign rd_b_data = read_sel(rd_b_sel);

    // Write-port decode
    logic [IDX_W-1:0] w_idx, w_hi, w_lo;
    logic             w_in_range;
    assign w_idx      = wr_sel[IDX_W-1:0];
    assign w_hi       = {w_idx[IDX_W-1:1], 1'b0};
    assign w_lo       = {w_idx[IDX_W-1:1], 1'b1};
    assign w_in_range = ({1'b0, w_idx} < REG_LIMIT);

    // Op-port decode and arithmetic
    logic [IDX_W-1:0] a_hi, a_lo, b_hi, b_lo, x_hi, x_lo;
    logic             a_valid, b_valid, x_valid_b;
    logic             is_arith, accept;
    logic [PW-1:0]    pair_a, pair_b, arith_result;
    logic [PW:0]      sum;
    logic             arith_carry;

    assign a_hi = {op_pair, 1'b0};
    assign a_lo = {op_pair, 1'b1};
    assign b_hi = {op_pair2, 1'b0};
    assign b_lo = {op_pair2, 1'b1};
    assign x_hi = {xchg_b, 1'b0};
    assign x_lo = {xchg_b, 1'b1};
    assign a_valid   = ({1'b0, op_pair} < PAIR_LIMIT);
    assign b_valid   = ({1'b0, op_pair2} < PAIR_LIMIT);
    assign x_valid_b = ({1'b0, xchg_b} < PAIR_LIMIT);
    assign pair_a = a_valid ? {r[a_hi], r[a_lo]} : '0;
    assign pair_b = b_valid ? {r[b_hi], r[b_lo]} : '0;
    assign accept = op_valid && op_ready;

    // NOTE: every variable written in an always_comb gets a default first, so no
    // path through the case statements can leave it holding a value (no latch).
    always_comb begin
        sum         = '0;
        arith_carry = 1'b0;
        is_arith    = 1'b1;
        case (op_code)
            OP_INC:  sum = {1'b0, pair_a} + (PW + 1)'(1);
            OP_INC2: sum = {1'b0, pair_a} + (PW + 1)'(2);
            OP_ADDI: sum = {1'b0, pair_a} + {1'b0, {DATA_W{op_imm[DATA_W-1]}}, op_imm};
            OP_DEC:  sum = {1'b0, pair_a} - (PW + 1)'(1);
            default: is_arith = 1'b0;
        endcase
        arith_result = sum[PW-1:0];
        // DEC reports a borrow, which only happens when the pair was zero.
        arith_carry  = (op_code == OP_DEC) ? (pair_a == '0) : sum[PW];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (op_code == OP_XCHG) state_next = XCHG2;
                    else                    done_next  = 1'b1;
                end
            end
            XCHG2: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; within this block
    // the op writes come after the write-port writes, so the op wins any shared byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is flip-flop storage that must read 0 after
            // reset, so every entry is cleared here rather than left uninitialised.
            for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
            temp     <= '0;
            xchg_b   <= '0;
            xchg_ok  <= 1'b0;
            op_zero  <= 1'b0;
            op_carry <= 1'b0;
            op_done  <= 1'b0;
        end else begin
            op_done <= done_next;

            if (we && w_in_range) begin
                if (wr_sel[IDX_W]) begin
                    r[w_hi] <= wr_data[PW-1:DATA_W];
                    r[w_lo] <= wr_data[DATA_W-1:0];
                end else begin
                    r[w_idx] <= wr_data[DATA_W-1:0];
                end
            end

            if (state == XCHG2) begin
                if (xchg_ok && x_valid_b) {r[x_hi], r[x_lo]} <= temp;
            end else if (accept) begin
                if (op_code == OP_XCHG) begin
                    temp    <= pair_a;
                    xchg_b  <= op_pair2;
                    xchg_ok <= a_valid && b_valid;
                    if (a_valid && b_valid) {r[a_hi], r[a_lo]} <= pair_b;
                end else if (is_arith && a_valid) begin
                    {r[a_hi], r[a_lo]} <= arith_result;
                    op_zero  <= (arith_result == '0);
                    op_carry <= arith_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_pair_reg_file.sv
// Directed bench for pair_reg_file: a table of read/write vectors followed by
// hand-written sequences for ops, XCHG timing, same-edge conflicts and reset.
module tb_pair_reg_file;

    localparam int DATA_W    = 8;
    localparam int NUM_PAIRS = 6;
    localparam int IDX_W     = 4;
    localparam int PAIR_W    = 3;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_INC  = 3'd1;
    localparam logic [2:0] C_DEC  = 3'd2;
    localparam logic [2:0] C_INC2 = 3'd3;
    localparam logic [2:0] C_ADDI = 3'd4;
    localparam logic [2:0] C_XCHG = 3'd5;
    localparam logic [2:0] C_RSV  = 3'd6;

    logic                clk = 1'b0;
    logic                rst;
    logic [IDX_W:0]      rd_a_sel, rd_b_sel, wr_sel;
    logic [2*DATA_W-1:0] rd_a_data, rd_b_data, wr_data;
    logic                we, op_valid, op_ready, op_done, op_zero, op_carry;
    logic [2:0]          op_code;
    logic [PAIR_W-1:0]   op_pair, op_pair2;
    logic [DATA_W-1:0]   op_imm;

    pair_reg_file #(.DATA_W(DATA_W), .NUM_PAIRS(NUM_PAIRS)) dut (
        .clk(clk), .rst(rst),
        .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data),
        .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data),
        .we(we), .wr_sel(wr_sel), .wr_data(wr_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_pair(op_pair), .op_pair2(op_pair2), .op_imm(op_imm),
        .op_done(op_done), .op_zero(op_zero), .op_carry(op_carry)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        logic         we;
        logic [4:0]   wr_sel;
        logic [15:0]  wr_data;
        logic [4:0]   rd_a_sel;
        logic [15:0]  exp_a;
        logic [4:0]   rd_b_sel;
        logic [15:0]  exp_b;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pair_sel(input int p);
        logic [31:0] pv;
        pv = p;
        return {1'b1, pv[2:0], 1'b0};
    endfunction

    task automatic expect_pair(input string name, input int p, input logic [15:0] exp);
        rd_a_sel = pair_sel(p);
        #1;
        check(name, rd_a_data, exp);
    endtask

    task automatic wr(input logic [4:0] sel, input logic [15:0] data);
        we = 1'b1; wr_sel = sel; wr_data = data;
        tick();
        we = 1'b0;
    endtask

    task automatic drive_op(input logic [2:0] code, input logic [2:0] p, input logic [2:0] p2,
                            input logic [7:0] imm);
        op_valid = 1'b1; op_code = code; op_pair = p; op_pair2 = p2; op_imm = imm;
    endtask

    task automatic do_op(input logic [2:0] code, input logic [2:0] p, input logic [2:0] p2,
                         input logic [7:0] imm);
        drive_op(code, p, p2, imm);
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"wr pair2 ext",      1'b1, 5'h14, 16'h1234, 5'h14, 16'h1234, 5'h04, 16'h0012};
        vecs[1] = '{"wr byte5",          1'b1, 5'h05, 16'hFFAB, 5'h05, 16'h00AB, 5'h15, 16'h12AB};
        vecs[2] = '{"wr ext odd idx",    1'b1, 5'h15, 16'h5678, 5'h14, 16'h5678, 5'h05, 16'h0078};
        vecs[3] = '{"wr byte12 ignored", 1'b1, 5'h0C, 16'hFFFF, 5'h0C, 16'h0000, 5'h14, 16'h5678};
        vecs[4] = '{"wr ext oob",        1'b1, 5'h1D, 16'hFFFF, 5'h1F, 16'h0000, 5'h0D, 16'h0000};
        vecs[5] = '{"we low",            1'b0, 5'h14, 16'hAAAA, 5'h14, 16'h5678, 5'h00, 16'h0000};
        vecs[6] = '{"wr byte11",         1'b1, 5'h0B, 16'h00C3, 5'h1A, 16'h00C3, 5'h1B, 16'h00C3};
        vecs[7] = '{"wr byte10",         1'b1, 5'h0A, 16'h0044, 5'h1A, 16'h44C3, 5'h0A, 16'h0044};

        rst = 1'b1; we = 1'b0; wr_sel = '0; wr_data = '0;
        rd_a_sel = '0; rd_b_sel = '0;
        op_valid = 1'b0; op_code = C_NOP; op_pair = '0; op_pair2 = '0; op_imm = '0;
        tick(); tick();
        rst = 1'b0;

        check("reset op_ready", 16'(op_ready), 16'h1);
        check("reset op_done",  16'(op_done),  16'h0);
        check("reset op_zero",  16'(op_zero),  16'h0);
        check("reset op_carry", 16'(op_carry), 16'h0);
        check("reset rd_b",     rd_b_data,     16'h0000);
        expect_pair("reset pair2", 2, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            we = vecs[i].we; wr_sel = vecs[i].wr_sel; wr_data = vecs[i].wr_data;
            tick();
            we = 1'b0;
            rd_a_sel = vecs[i].rd_a_sel; rd_b_sel = vecs[i].rd_b_sel;
            #1;
            check({vecs[i].name, " A"}, rd_a_data, vecs[i].exp_a);
            check({vecs[i].name, " B"}, rd_b_data, vecs[i].exp_b);
        end

        // INC wraps 0xFFFF, then DEC borrows from 0
        wr(pair_sel(5), 16'hFFFF);
        do_op(C_INC, 3'd5, 3'd0, 8'h00);
        check("inc done",  16'(op_done),  16'h1);
        check("inc zero",  16'(op_zero),  16'h1);
        check("inc carry", 16'(op_carry), 16'h1);
        expect_pair("inc pair5", 5, 16'h0000);
        tick();
        check("inc done one cycle", 16'(op_done), 16'h0);
        do_op(C_DEC, 3'd5, 3'd0, 8'h00);
        expect_pair("dec pair5", 5, 16'hFFFF);
        check("dec carry", 16'(op_carry), 16'h1);
        check("dec zero",  16'(op_zero),  16'h0);

        // ADDI with negative immediate, then INC2 back to back
        wr(pair_sel(0), 16'h0100);
        drive_op(C_ADDI, 3'd0, 3'd0, 8'h80);
        tick();
        expect_pair("addi pair0", 0, 16'h0080);
        check("addi carry", 16'(op_carry), 16'h1);
        check("addi ready", 16'(op_ready), 16'h1);
        drive_op(C_INC2, 3'd0, 3'd0, 8'h00);
        tick();
        op_valid = 1'b0;
        expect_pair("inc2 pair0", 0, 16'h0082);
        check("inc2 done", 16'(op_done),  16'h1);
        check("inc2 carry", 16'(op_carry), 16'h0);

        // XCHG(1,2), with an INC offered during XCHG2 that must be ignored
        wr(pair_sel(1), 16'hDEAD);
        wr(pair_sel(2), 16'hBEEF);
        drive_op(C_XCHG, 3'd1, 3'd2, 8'h00);
        tick();
        drive_op(C_INC, 3'd1, 3'd0, 8'h00);
        check("xchg ready low", 16'(op_ready), 16'h0);
        check("xchg mid done",  16'(op_done),  16'h0);
        expect_pair("xchg mid pair1", 1, 16'hBEEF);
        expect_pair("xchg mid pair2", 2, 16'hBEEF);
        tick();
        op_valid = 1'b0;
        expect_pair("xchg end pair1", 1, 16'hBEEF);
        expect_pair("xchg end pair2", 2, 16'hDEAD);
        check("xchg done",     16'(op_done),  16'h1);
        check("xchg ready up", 16'(op_ready), 16'h1);
        tick();
        check("xchg done one cycle", 16'(op_done), 16'h0);

        // Same-edge conflicts between the write port and an op
        wr(pair_sel(3), 16'h00FF);
        we = 1'b1; wr_sel = pair_sel(3); wr_data = 16'h5555;
        do_op(C_INC, 3'd3, 3'd0, 8'h00);
        we = 1'b0;
        expect_pair("conflict op wins", 3, 16'h0100);
        we = 1'b1; wr_sel = 5'h08; wr_data = 16'h0077;
        do_op(C_INC, 3'd3, 3'd0, 8'h00);
        we = 1'b0;
        expect_pair("conflict inc pair3", 3, 16'h0101);
        rd_b_sel = 5'h08;
        #1;
        check("conflict byte8", rd_b_data, 16'h0077);

        // XCHG of a pair with itself
        do_op(C_XCHG, 3'd2, 3'd2, 8'h00);
        check("self xchg ready low", 16'(op_ready), 16'h0);
        tick();
        check("self xchg done", 16'(op_done), 16'h1);
        expect_pair("self xchg pair2", 2, 16'hDEAD);

        // Reset during XCHG2 abandons the swap
        do_op(C_XCHG, 3'd0, 3'd1, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst xchg ready", 16'(op_ready), 16'h1);
        check("rst xchg done",  16'(op_done),  16'h0);
        for (int p = 0; p < NUM_PAIRS; p++) expect_pair($sformatf("rst pair%0d", p), p, 16'h0000);
        tick();
        check("rst no late done", 16'(op_done), 16'h0);

        // Invalid pair indices and reserved codes leave state alone
        wr(pair_sel(5), 16'hFFFF);
        do_op(C_INC, 3'd5, 3'd0, 8'h00);
        wr(pair_sel(4), 16'h1111);
        do_op(C_INC, 3'd7, 3'd0, 8'h00);
        check("bad pair done",  16'(op_done),  16'h1);
        check("bad pair zero",  16'(op_zero),  16'h1);
        check("bad pair carry", 16'(op_carry), 16'h1);
        expect_pair("bad pair pair4", 4, 16'h1111);
        expect_pair("bad pair pair5", 5, 16'h0000);
        do_op(C_RSV, 3'd4, 3'd0, 8'h00);
        check("rsv done", 16'(op_done), 16'h1);
        expect_pair("rsv pair4", 4, 16'h1111);
        do_op(C_XCHG, 3'd7, 3'd4, 8'h00);
        check("bad xchg ready low", 16'(op_ready), 16'h0);
        check("bad xchg mid done",  16'(op_done),  16'h0);
        tick();
        check("bad xchg done", 16'(op_done), 16'h1);
        expect_pair("bad xchg pair4", 4, 16'h1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pair_reg_file.md
# pair_reg_file

Parametrised successor to the CPU's byte/pair register file. It holds `2*NUM_PAIRS` registers of `DATA_W` bits and provides two combinational read ports and one write port. Pair operations (increment, decrement, add signed immediate, and a two-cycle pair exchange) go through a valid/ready op port and report done, zero and carry status. It sits between the control sequencer and the datapath bus, and covers BC/DE/HL/WZ/PC/SP pair handling plus XCHG-style swaps.

## Interface
Parameters:
- `DATA_W`, 8, width of one byte register; pairs are `2*DATA_W` wide.
- `NUM_PAIRS`, 6, number of register pairs; byte registers are indexed 0 to `2*NUM_PAIRS-1`.
- `IDX_W`, `$clog2(2*NUM_PAIRS)`, byte index width (derived).
- `PAIR_W`, `$clog2(NUM_PAIRS)`, pair index width (derived).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `rd_a_sel`  in  `IDX_W+1`  read port A select; MSB = ext (pair), low bits = byte index.
- `rd_a_data`  out  `2*DATA_W`  read port A data, combinational.
- `rd_b_sel`  in  `IDX_W+1`  read port B select, same encoding as port A.
- `rd_b_data`  out  `2*DATA_W`  read port B data, combinational.
- `we`  in  1  write enable.
- `wr_sel`  in  `IDX_W+1`  write select, same encoding as the read ports.
- `wr_data`  in  `2*DATA_W`  write data.
- `op_valid`  in  1  pair op request.
- `op_ready`  out  1  op port can accept a request.
- `op_code`  in  3  op: 0 NOP, 1 INC, 2 DEC, 3 INC2, 4 ADDI, 5 XCHG; 6 and 7 are reserved.
- `op_pair`  in  `PAIR_W`  target pair index.
- `op_pair2`  in  `PAIR_W`  second pair, used by XCHG only.
- `op_imm`  in  `DATA_W`  signed immediate, used by ADDI only.
- `op_done`  out  1  one-cycle pulse when an op completes.
- `op_zero`  out  1  last arithmetic result was zero.
- `op_carry`  out  1  last arithmetic op wrapped (carry or borrow).

## Operation
- Storage is `r[0..2*NUM_PAIRS-1]`. Pair p is `{r[2p], r[2p+1]}`, with the high byte at the even index.
- Reads:
  - ext=1: the low bit of the index is forced to 0; data = `{r[i], r[i+1]}`.
  - ext=0: data = `{0, r[i]}`.
  - An index ≥ `2*NUM_PAIRS` reads 0.
  - Reads return current register state only; there is no write bypass.
- Writes (`we`):
  - ext=1: the aligned pair gets `wr_data`.
  - ext=0: `r[i]` gets `wr_data[DATA_W-1:0]`.
  - An out-of-range index is ignored.
- Arithmetic ops (INC +1, DEC -1, INC2 +2, ADDI + sign-extended `op_imm`):
  - All are modulo `2^(2*DATA_W)`.
  - `op_carry`: for INC, INC2 and ADDI, the unsigned carry out of the MSB; for DEC, the borrow (pair was 0).
  - `op_zero` = (result == 0).
  - Both flags are registered and updated only by arithmetic ops on a valid pair.
- State machine: IDLE and XCHG2.
  - IDLE: `op_ready`=1. An accepted arithmetic op commits at that edge; the state stays IDLE.
  - IDLE, accepted XCHG: at that edge `temp` gets pair A (`op_pair`), pair A gets pair B (`op_pair2`), and the state goes to XCHG2.
  - XCHG2: `op_ready`=0 and op inputs are ignored. At the next edge pair B gets `temp` and the state returns to IDLE.
- `op_done`: registered. It is high for exactly the cycle after the committing edge (arithmetic: the accept edge; XCHG: the XCHG2 edge).
- Boundary cases:
  - NOP, a reserved code, or `op_pair`/`op_pair2` ≥ `NUM_PAIRS`: accepted, no register or flag change, `op_done` still pulses. An invalid XCHG still takes two cycles.
  - XCHG with `op_pair == op_pair2`: no value change, two cycles, `op_done` pulses.
- Same-edge conflict between `we` and an op write (including either XCHG phase): the op wins on every byte it writes. Bytes of `we` outside the op's pair are still written.
- Reset: all registers, `temp`, `op_zero`, `op_carry` and `op_done` go to 0, and the state goes to IDLE. A reset during XCHG2 abandons the swap and produces no `op_done`.

## Timing
- Read latency is 0 cycles (combinational from select and state). Write and arithmetic-op latency is 1 edge.
- XCHG takes 2 edges. Between them, pair A already shows old B and pair B still shows old B.
- Throughput:
  - Arithmetic ops: one per cycle, back to back.
  - XCHG: one every 2 cycles; the accept cycle after an XCHG is at the earliest 2 cycles later.
- Output values after reset: `op_ready`=1, `op_done`=0, `op_zero`=0, `op_carry`=0, read data 0.

## Test plan
- Reset, then write pair 2 = 0x1234 with ext and byte 5 = 0xAB without ext. Required: port A pair 2 reads 0x1234, port B byte 5 reads 0x00AB, ext read of byte index 5 reads `{r4, r5}`.
- Pair 5 = 0xFFFF, then INC. Required: pair 5 = 0x0000, `op_zero`=1, `op_carry`=1, `op_done` high for exactly one cycle. Then DEC: pair 5 = 0xFFFF, `op_carry`=1, `op_zero`=0.
- Pair 0 = 0x0100, then ADDI with `op_imm`=0x80 (-128). Required: pair 0 = 0x0080 and `op_carry`=1. Then INC2 back to back on the next cycle: pair 0 = 0x0082.
- Pair 1 = 0xDEAD, pair 2 = 0xBEEF, then XCHG(1,2). Required: `op_ready`=0 for one cycle, intermediate state pair 1 = 0xBEEF with pair 2 = 0xBEEF, final pair 1 = 0xBEEF and pair 2 = 0xDEAD, `op_done` one cycle after XCHG2.
- Same edge: INC on pair 3 (0x00FF) plus an ext `we` of 0x5555 to pair 3. Required: pair 3 = 0x0100. Same edge: INC on pair 3 plus a non-ext `we` to byte 8. Required: both commit.
- Assert `rst` during XCHG2. Required: all pairs 0, `op_ready`=1, no `op_done`. An op with `op_pair`=7 must not change any register or flag and must still pulse `op_done`.
